// File: rtl/frida_spi_cfg_pkg.sv
// Shared constants, field map and state encoding for the FRIDA SPI configuration slave.
package frida_spi_cfg_pkg;

    localparam int unsigned CfgWidth = 180;
    localparam int unsigned CntW     = $clog2(CfgWidth + 1);

    localparam logic [CntW-1:0] BitCntLast = CntW'(CfgWidth - 1);
    localparam logic [CntW-1:0] BitCntSat  = CntW'(CfgWidth + 1);

    // Field map: ADC i at [11*i+14 : 11*i+4], comparator-mux select at [3:0].
    localparam int unsigned AdcNum      = 16;
    localparam int unsigned AdcFieldW   = 11;
    localparam int unsigned AdcLsbBase  = 4;
    localparam int unsigned CompMuxSelW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone,
        StOver
    } state_e;

    function automatic int unsigned adc_lsb(input int unsigned idx);
        return AdcFieldW * idx + AdcLsbBase;
    endfunction

    function automatic logic [AdcFieldW-1:0] adc_field(input logic [CfgWidth-1:0] cfg,
                                                       input int unsigned idx);
        return cfg[adc_lsb(idx) +: AdcFieldW];
    endfunction

endpackage

// File: rtl/frida_spi_cfg_if.sv
// SPI data-path signals between the pad ring (master side) and the config slave.
interface frida_spi_cfg_if;
    logic cs_b;
    logic sdi;
    logic sdo;

    modport master (
        output cs_b,
        output sdi,
        input  sdo
    );

    modport slave (
        input  cs_b,
        input  sdi,
        output sdo
    );
endinterface

// File: rtl/frida_spi_cfg.sv
// SPI slave holding the 180-bit configuration; reads the old value out while the new one
// shifts in and commits only complete frames.
module frida_spi_cfg
    import frida_spi_cfg_pkg::*;
(
    input  logic                i_spi_sclk,
    input  logic                i_rst,
    frida_spi_cfg_if.slave      spi,
    output logic [CfgWidth-1:0] o_cfg_q,
    output logic                o_cfg_valid,
    output logic                o_frame_err
);

    logic [CfgWidth-1:0] r_cfg;
    logic [CfgWidth-1:0] r_shreg;
    logic [CntW-1:0]     r_bit_cnt;
    state_e              r_state;
    logic                r_cfg_valid;
    logic                r_frame_err;

    logic [CfgWidth-1:0] w_src;
    logic [CfgWidth-1:0] w_shift_next;

    // The first bit of a frame loads from cfg_q so the old configuration streams out on sdo.
    assign w_src        = (r_bit_cnt == '0) ? r_cfg : r_shreg;
    assign w_shift_next = {w_src[CfgWidth-2:0], spi.sdi};

    assign spi.sdo     = i_rst ? 1'b0 : w_src[CfgWidth-1];
    assign o_cfg_q     = r_cfg;
    assign o_cfg_valid = r_cfg_valid;
    assign o_frame_err = r_frame_err;

    always_ff @(posedge i_spi_sclk) begin
        if (i_rst) begin
            r_cfg       <= '0;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_state     <= StIdle;
            r_cfg_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_cfg_valid <= 1'b0;
            if (spi.cs_b) begin
                r_bit_cnt <= '0;
                r_state   <= StIdle;
                if (r_state == StShift) begin
                    r_frame_err <= 1'b1;
                end
            end else begin
                r_shreg <= w_shift_next;
                if (r_bit_cnt != BitCntSat) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                unique case (r_state)
                    StIdle: begin
                        r_state <= StShift;
                    end
                    StShift: begin
                        if (r_bit_cnt == BitCntLast) begin
                            r_cfg       <= w_shift_next;
                            r_cfg_valid <= 1'b1;
                            r_state     <= StDone;
                        end
                    end
                    StDone: begin
                        r_state     <= StOver;
                        r_frame_err <= 1'b1;
                    end
                    StOver: begin
                        r_state <= StOver;
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frida_spi_cfg.sv
// Self-checking bench: table of frames with a cfg/err model and an sdo readback scoreboard.
module tb_frida_spi_cfg;
    import frida_spi_cfg_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frida_spi_cfg_if spi_if ();

    logic [CfgWidth-1:0] cfg_q;
    logic                cfg_valid;
    logic                frame_err;

    frida_spi_cfg dut (
        .i_spi_sclk  (clk),
        .i_rst       (rst),
        .spi         (spi_if),
        .o_cfg_q     (cfg_q),
        .o_cfg_valid (cfg_valid),
        .o_frame_err (frame_err)
    );

    typedef struct {
        string       name;
        int          nbits;
        logic [7:0]  pat;
        logic        exp_err;
        int          exp_pulses;
    } frame_vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [CfgWidth-1:0] m_cfg;
    logic                m_err;
    logic                sdo_q[$];
    int                  pulses;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkv(input string name, input logic [CfgWidth-1:0] act,
                        input logic [CfgWidth-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Every step starts at a negedge: drive, settle, take the active edge, sample at negedge.
    task automatic edge_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_frame(input string name, input int n, input logic [7:0] pat);
        logic [CfgWidth-1:0] old_cfg;
        logic [CfgWidth-1:0] nxt_cfg;
        logic                b;
        old_cfg = m_cfg;
        nxt_cfg = m_cfg;
        pulses  = 0;
        for (int k = 1; k <= n; k++) begin
            b = pat[7 - ((k - 1) % 8)];
            spi_if.cs_b = 1'b0;
            spi_if.sdi  = b;
            if (k <= CfgWidth) begin
                sdo_q.push_back(old_cfg[CfgWidth-k]);
                nxt_cfg[CfgWidth-k] = b;
            end
            #2;
            if (sdo_q.size() > 0) chk1({name, ".sdo"}, spi_if.sdo, sdo_q.pop_front());
            edge_step();
            if (cfg_valid === 1'b1) pulses++;
            chk1({name, ".cfg_valid"}, cfg_valid, (k == CfgWidth));
            if (k == CfgWidth) m_cfg = nxt_cfg;
            if (k == CfgWidth + 1) m_err = 1'b1;
            chk1({name, ".frame_err"}, frame_err, m_err);
            chkv({name, ".cfg_q"}, cfg_q, m_cfg);
        end
        spi_if.cs_b = 1'b1;
        spi_if.sdi  = 1'b0;
        edge_step();
        if (n > 0 && n < CfgWidth) m_err = 1'b1;
        chk1({name, ".end_valid"}, cfg_valid, 1'b0);
        chk1({name, ".end_err"}, frame_err, m_err);
        chkv({name, ".end_cfg"}, cfg_q, m_cfg);
    endtask

    frame_vec_t vecs[4];

    initial begin
        vecs[0] = '{name: "a5_frame",    nbits: 180, pat: 8'hA5, exp_err: 1'b0, exp_pulses: 1};
        vecs[1] = '{name: "ones_frame",  nbits: 180, pat: 8'hFF, exp_err: 1'b0, exp_pulses: 1};
        vecs[2] = '{name: "short_frame", nbits: 100, pat: 8'h3C, exp_err: 1'b1, exp_pulses: 0};
        vecs[3] = '{name: "over_frame",  nbits: 182, pat: 8'h5A, exp_err: 1'b1, exp_pulses: 1};

        spi_if.cs_b = 1'b1;
        spi_if.sdi  = 1'b0;
        rst         = 1'b1;
        m_cfg       = '0;
        m_err       = 1'b0;
        @(negedge clk);
        edge_step();
        edge_step();
        chkv("rst.cfg_q", cfg_q, '0);
        chk1("rst.sdo", spi_if.sdo, 1'b0);
        chk1("rst.cfg_valid", cfg_valid, 1'b0);
        chk1("rst.frame_err", frame_err, 1'b0);
        rst = 1'b0;
        edge_step();

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].name, vecs[i].nbits, vecs[i].pat);
            chki({vecs[i].name, ".pulses"}, pulses, vecs[i].exp_pulses);
            chk1({vecs[i].name, ".err_tab"}, frame_err, vecs[i].exp_err);
        end

        // Reset asserted on bit 90 of a frame.
        for (int k = 1; k <= 89; k++) begin
            spi_if.cs_b = 1'b0;
            spi_if.sdi  = k[0];
            edge_step();
        end
        spi_if.sdi = 1'b1;
        rst        = 1'b1;
        #2;
        chk1("midrst.sdo_gated", spi_if.sdo, 1'b0);
        edge_step();
        chkv("midrst.cfg_q", cfg_q, '0);
        chk1("midrst.cfg_valid", cfg_valid, 1'b0);
        chk1("midrst.frame_err", frame_err, 1'b0);
        chk1("midrst.sdo", spi_if.sdo, 1'b0);
        rst         = 1'b0;
        spi_if.cs_b = 1'b1;
        m_cfg       = '0;
        m_err       = 1'b0;
        edge_step();
        run_frame("clean_frame", 180, 8'hC3);
        chki("clean_frame.pulses", pulses, 1);
        chk1("clean_frame.err", frame_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
